// File: rtl/request_pkg.sv
// Shared types and constants for the memory request unit.
package request_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DATA  = 2'd2,
        WB    = 2'd3
    } req_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/req_watchdog.sv
// Saturating wait-cycle counter that flags a stalled RAM access.
module req_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else if (enable && cnt != SAT)
            cnt <= cnt + 1'b1;
    end

    // Fires during the TIMEOUT-th waiting cycle so the state is left right after it.
    assign expired = (TIMEOUT > 0) && enable && (cnt >= LIMIT);

endmodule

// File: rtl/request_unit.sv
// Serialises instruction fetch and data access onto a single RAM port and
// holds the fetched instruction stable while the core executes it.
module request_unit
    import request_pkg::*;
#(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] NOP     = NOP_INSTR
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        i_ready,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic        dmmRen,
    input  logic        dmmWen,
    output logic [31:0] dmmload,
    output logic        d_ready,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramRen,
    output logic        ramWen,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        err
);

    req_state_t state, state_nxt;
    logic       mem_req;
    logic       wd_en, wd_clr, wd_expired;

    assign mem_req = dmmRen | dmmWen;
    assign wd_en   = ((state == FETCH) || (state == DATA)) && !ram_ack;
    assign wd_clr  = nRST || (state_nxt != state);

    req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .clear   (wd_clr),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (nRST)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (ram_ack || wd_expired) state_nxt = EXEC;
            EXEC:  state_nxt = mem_req ? DATA : FETCH;
            DATA: begin
                if (ram_ack)
                    state_nxt = WB;
                else if (wd_expired)
                    state_nxt = FETCH;
            end
            WB:    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // An aborted fetch substitutes NOP so the core still retires a harmless instruction.
    always_ff @(posedge clk) begin
        if (nRST) begin
            imemload <= NOP;
            dmmload  <= '0;
            err      <= 1'b0;
        end else begin
            if (state == FETCH) begin
                if (ram_ack)
                    imemload <= ramload;
                else if (wd_expired)
                    imemload <= NOP;
            end
            if (state == DATA && ram_ack && !dmmWen)
                dmmload <= ramload;
            if (wd_expired)
                err <= 1'b1;
        end
    end

    // Reset gates every strobe combinationally so an in-flight access drops at once.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramRen   = 1'b0;
        ramWen   = 1'b0;
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        if (!nRST) begin
            case (state)
                FETCH: begin
                    ramRen  = 1'b1;
                    ramaddr = {imemaddr[31:2], 2'b00};
                end
                EXEC: i_ready = !mem_req;
                DATA: begin
                    ramaddr  = {dmmaddr[31:2], 2'b00};
                    ramstore = dmmstore;
                    ramWen   = dmmWen;
                    ramRen   = !dmmWen;
                end
                WB: begin
                    i_ready = 1'b1;
                    d_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
